// File: rtl/mdu_seq_ctrl_pkg.sv
// mdu_seq_ctrl_pkg
//   Shared types and constants for the RV32M multiply/divide sequencer.
//   mdu_op_e    : funct3 encodings of the eight M-extension ops
//   mdu_state_e : sequencer FSM states
//   MDU_CNT_W   : step-counter width for the default XLEN
package mdu_seq_ctrl_pkg;

  localparam int unsigned MDU_XLEN  = 32;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_XLEN);

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } mdu_state_e;

  // Operand a is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // Operand b is treated as signed for MULH, DIV and REM.
  function automatic logic op_signed_b(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/mdu_seq_ctrl_iter_dp.sv
// mdu_iter_dp
//   Iterative unsigned multiply / restoring-divide datapath, one step per cycle.
//   Multiply: hi accumulates, lo holds the multiplier and shifts right; after
//             XLEN steps {hi,lo} is the 2*XLEN product of r_b and the original lo.
//   Divide:   hi is the partial remainder, lo holds the dividend and fills with
//             quotient bits; after XLEN steps hi=remainder, lo=quotient.
// Ports
//   clk_i, rst_ni           clock, async active-low reset
//   load_i                  load hi/lo/b from load_*_i (has priority over step)
//   step_i                  perform one iteration
//   div_i                   1: divide step, 0: multiply step
//   load_hi_i/lo_i/b_i      load values
//   hi_o, lo_o              working registers
module mdu_iter_dp #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] load_hi_i,
  input  logic [XLEN-1:0] load_lo_i,
  input  logic [XLEN-1:0] load_b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_div_diff;

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    w_div_shift = {r_hi, r_lo[XLEN-1]};
    // Partial remainder stays below r_b, so bit XLEN of the difference is a clean borrow flag.
    w_div_diff  = w_div_shift - {1'b0, r_b};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi <= '0;
      r_lo <= '0;
      r_b  <= '0;
    end else if (load_i) begin
      r_hi <= load_hi_i;
      r_lo <= load_lo_i;
      r_b  <= load_b_i;
    end else if (step_i) begin
      if (div_i) begin
        if (!w_div_diff[XLEN]) begin
          r_hi <= w_div_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_div_shift[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl
//   Sequencer for the shared iterative RV32M multiply/divide datapath in Execute.
//   Accepts one M-op, stalls the pipeline until the result is ready, aborts on flush.
//   Optional macro MDU_FAST_MUL_EN: multiplies use a single-cycle '*' product
//   (PREP->FIN, latency 2); divides are unchanged.
// Ports
//   clk_i     clock              rst_ni   async active-low reset
//   start_i   E holds a valid M-op (held while stalled)
//   op_i      funct3 of the M-op rs1_i/rs2_i  operands a / b
//   flush_i   kill in-flight op
//   result_o  result, valid with done_o        done_o  one-cycle result pulse
//   busy_o    state != IDLE                    stall_o freeze F/D/E
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            stall_o
);

  localparam int unsigned     CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      r_state;
  mdu_state_e      w_next;
  mdu_op_e         r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            r_sa;
  logic            r_sb;
  logic            r_skip_fix;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_is_div;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic              w_fast_mul;
  logic              w_accept;
  logic [XLEN-1:0]   w_ld_hi;
  logic [XLEN-1:0]   w_ld_lo;
  logic [XLEN-1:0]   w_ld_b;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_res;
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
`endif

  assign w_accept   = (r_state == IDLE) && start_i && !flush_i;
  assign w_abs_a    = r_sa ? (~r_a + 1'b1) : r_a;
  assign w_abs_b    = r_sb ? (~r_b + 1'b1) : r_b;
  assign w_is_div   = op_is_div(r_op);
  assign w_div_zero = w_is_div && (r_b == '0);
  assign w_ovf      = ((r_op == MDU_DIV) || (r_op == MDU_REM)) && (r_a == MIN_NEG) && (r_b == '1);
  assign w_special  = w_div_zero || w_ovf;

`ifdef MDU_FAST_MUL_EN
  assign w_fast_prod = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};
  assign w_fast_mul  = !w_is_div;
`else
  assign w_fast_mul  = 1'b0;
`endif

  // PREP load values. Special cases preload the final quotient (lo) and
  // remainder (hi) so FIN can select them without any sign fix.
  always_comb begin
    w_ld_hi = '0;
    w_ld_lo = '0;
    w_ld_b  = '0;
    if (w_div_zero) begin
      w_ld_hi = r_a;
      w_ld_lo = '1;
    end else if (w_ovf) begin
      w_ld_lo = r_a;
    end else if (w_is_div) begin
      w_ld_lo = w_abs_a;
      w_ld_b  = w_abs_b;
    end else begin
`ifdef MDU_FAST_MUL_EN
      w_ld_hi = w_fast_prod[2*XLEN-1:XLEN];
      w_ld_lo = w_fast_prod[XLEN-1:0];
`else
      w_ld_lo = w_abs_b;
      w_ld_b  = w_abs_a;
`endif
    end
  end

  mdu_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (r_state == PREP),
    .step_i    (r_state == CALC),
    .div_i     (w_is_div),
    .load_hi_i (w_ld_hi),
    .load_lo_i (w_ld_lo),
    .load_b_i  (w_ld_b),
    .hi_o      (w_hi),
    .lo_o      (w_lo)
  );

  // Sign fix and result select, only meaningful in FIN.
  always_comb begin
    w_prod_fix = (r_sa ^ r_sb) ? (~{w_hi, w_lo} + 1'b1) : {w_hi, w_lo};
    w_q_fix    = (!r_skip_fix && (r_sa ^ r_sb)) ? (~w_lo + 1'b1) : w_lo;
    w_r_fix    = (!r_skip_fix && r_sa) ? (~w_hi + 1'b1) : w_hi;
    case (r_op)
      MDU_MUL:                         w_res = w_prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_res = w_prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               w_res = w_q_fix;
      default:                         w_res = w_r_fix;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op       <= MDU_MUL;
      r_a        <= '0;
      r_b        <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_skip_fix <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_op <= mdu_op_e'(op_i);
        r_a  <= rs1_i;
        r_b  <= rs2_i;
        r_sa <= op_signed_a(mdu_op_e'(op_i)) && rs1_i[XLEN-1];
        r_sb <= op_signed_b(mdu_op_e'(op_i)) && rs2_i[XLEN-1];
      end
      if (r_state == PREP) begin
        r_cnt      <= CNT_W'(XLEN - 1);
        r_skip_fix <= w_special;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    busy_o   = (r_state != IDLE);
    stall_o  = start_i && (r_state != FIN) && !flush_i;
    done_o   = 1'b0;
    result_o = '0;
    if (flush_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start_i) w_next = PREP;
        PREP: w_next = (w_special || w_fast_mul) ? FIN : CALC;
        CALC: if (r_cnt == '0) w_next = FIN;
        FIN: begin
          w_next   = IDLE;
          done_o   = 1'b1;
          result_o = w_res;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
module tb_mdu_seq_ctrl;
  import mdu_seq_ctrl_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DIV_LAT = XLEN + 2;
  localparam int unsigned SPC_LAT = 2;
`ifdef MDU_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 2;
`else
  localparam int unsigned MUL_LAT = XLEN + 2;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [2:0]      op_i = 3'b000;
  logic [XLEN-1:0] rs1_i = '0;
  logic [XLEN-1:0] rs2_i = '0;
  logic            flush_i = 1'b0;
  logic [XLEN-1:0] result_o;
  logic            done_o;
  logic            busy_o;
  logic            stall_o;

  mdu_seq_ctrl #(.XLEN(XLEN)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .result_o (result_o),
    .done_o   (done_o),
    .busy_o   (busy_o),
    .stall_o  (stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] res;
    int unsigned     due;
    string           name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  // Monitor: result/latency scoreboard plus the start-held protocol checker.
  always @(negedge clk_i) begin
    if (rst_ni && done_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h expected=no_done", result_o);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, result_o, mon_e.res);
        chk({mon_e.name, "_cycle"}, XLEN'(cyc), XLEN'(mon_e.due));
      end
    end
    if (rst_ni && busy_o && !flush_i) begin
      checks++;
      if (!start_i) begin
        failures++;
        $display("FAIL start_dropped actual=0 expected=1 cyc=%0d", cyc);
      end
    end
  end

  task automatic launch(input mdu_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
  endtask

  task automatic run(input string n, input mdu_op_e op, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int unsigned lat);
    exp_t e;
    bit   got;
    bit   stall_ok;
    launch(op, a, b);
    e.res  = exp;
    e.due  = cyc + lat;
    e.name = n;
    sb.push_back(e);
    got      = 1'b0;
    stall_ok = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      if (done_o) got = 1'b1;
      else if (stall_o !== 1'b1) stall_ok = 1'b0;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done", n);
      void'(sb.pop_back());
    end else begin
      chk({n, "_stall_release"}, XLEN'(stall_o), '0);
    end
    chk({n, "_stall_hold"}, XLEN'(stall_ok), XLEN'(1));
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_result", result_o, '0);
    chk("rst_done", XLEN'(done_o), '0);
    chk("rst_busy", XLEN'(busy_o), '0);
    chk("rst_stall", XLEN'(stall_o), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run("mul_7_m3", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    run("rem_ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);
    run("divu_z", MDU_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, SPC_LAT);
    run("remu_z", MDU_REMU, 32'd100, 32'd0, 32'd100, SPC_LAT);
    run("div_z", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPC_LAT);
    run("rem_z", MDU_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPC_LAT);
    run("rem_m7_2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    run("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    run("div_7_m2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    run("rem_7_m2", MDU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, DIV_LAT);
    run("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run("remu_100_7", MDU_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
    run("mulhu_max", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run("mulh_m7_3", MDU_MULH, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, MUL_LAT);
    run("mulh_min", MDU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run("mulhsu_m1", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run("mul_shift", MDU_MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT);

    // Flush in CALC (cycle 12 = CALC step 10): no done, idle next cycle.
    launch(MDU_DIVU, 32'd1000, 32'd3);
    repeat (12) @(posedge clk_i);
    #1;
    chk("flush_busy_before", XLEN'(busy_o), XLEN'(1));
    flush_i = 1'b1;
    #1;
    chk("flush_stall", XLEN'(stall_o), '0);
    chk("flush_done", XLEN'(done_o), '0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    chk("flush_busy_after", XLEN'(busy_o), '0);
    repeat (3) @(posedge clk_i);
    run("after_flush", MDU_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);

    // Async reset in CALC: outputs drop immediately.
    launch(MDU_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk_i);
    #1;
    chk("arst_busy_before", XLEN'(busy_o), XLEN'(1));
    rst_ni  = 1'b0;
    start_i = 1'b0;
    #1;
    chk("arst_busy", XLEN'(busy_o), '0);
    chk("arst_done", XLEN'(done_o), '0);
    chk("arst_result", result_o, '0);
    chk("arst_stall", XLEN'(stall_o), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run("mul_after_rst", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);

    repeat (3) @(posedge clk_i);
    chk("sb_empty", XLEN'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
